// File: rtl/pulse_scheduler.sv
// Round-robin shared pulse channel: one granted requester at a time drives a
// pulse of its requested width on `signal`, followed by a forced low gap.
module pulse_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_W = 4,
    parameter int GAP     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [WIDTH_W-1:0] width,
    output logic               signal,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam int unsigned NR = N_REQ;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t             state, state_n;
    logic [WIDTH_W-1:0] count, count_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [PTR_W-1:0]   last, last_n;
    logic               signal_n, busy_n;
    logic [N_REQ-1:0]   grant_n, done_n;

    logic [PTR_W-1:0]   winner;
    logic               found;
    int unsigned        idx;
    logic [N_REQ-1:0]   win_onehot;
    logic [WIDTH_W-1:0] load_cnt;

    // Search last+1, last+2, ... so the most recent owner has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx = (32'(last) + i) % NR;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    assign win_onehot = N_REQ'(1) << winner;
    assign load_cnt   = (width == '0) ? WIDTH_W'(1) : width;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            gap_cnt <= '0;
            last    <= PTR_W'(N_REQ - 1);
            signal  <= 1'b0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            gap_cnt <= gap_n;
            last    <= last_n;
            signal  <= signal_n;
            grant   <= grant_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (found) state_n = ST_PULSE;
            ST_PULSE: if (count == WIDTH_W'(1)) state_n = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt == GAP_W'(1)) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Computes next-cycle values of every registered output; done is raised
    // one edge early so it lines up with the count==1 pulse cycle.
    always_comb begin
        signal_n = 1'b0;
        grant_n  = '0;
        done_n   = '0;
        busy_n   = 1'b0;
        count_n  = count;
        gap_n    = gap_cnt;
        last_n   = last;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    signal_n = 1'b1;
                    grant_n  = win_onehot;
                    busy_n   = 1'b1;
                    last_n   = winner;
                    count_n  = load_cnt;
                    done_n   = (load_cnt == WIDTH_W'(1)) ? win_onehot : '0;
                end
            end
            ST_PULSE: begin
                if (count == WIDTH_W'(1)) begin
                    count_n = '0;
                    if (GAP > 0) begin
                        busy_n = 1'b1;
                        gap_n  = GAP_W'(GAP);
                    end
                end else begin
                    count_n  = count - WIDTH_W'(1);
                    signal_n = 1'b1;
                    grant_n  = grant;
                    busy_n   = 1'b1;
                    done_n   = (count == WIDTH_W'(2)) ? grant : '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    gap_n = '0;
                end else begin
                    gap_n  = gap_cnt - GAP_W'(1);
                    busy_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: per-cycle vector table plus sequences
// for rotation, max width and a GAP=0 instance.
module tb_pulse_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] width;
    logic       signal, busy;
    logic [3:0] grant, done;

    logic       rst0;
    logic [3:0] req0;
    logic [3:0] width0;
    logic       signal0, busy0;
    logic [3:0] grant0, done0;

    int checks   = 0;
    int failures = 0;
    bit inv_en   = 0;

    always #5 clk = ~clk;

    pulse_scheduler #(.N_REQ(4), .WIDTH_W(4), .GAP(2)) dut (
        .clock(clk), .reset(rst), .req(req), .width(width),
        .signal(signal), .grant(grant), .done(done), .busy(busy)
    );

    pulse_scheduler #(.N_REQ(4), .WIDTH_W(4), .GAP(0)) dut_nogap (
        .clock(clk), .reset(rst0), .req(req0), .width(width0),
        .signal(signal0), .grant(grant0), .done(done0), .busy(busy0)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] width;
        logic       sig;
        logic [3:0] gnt;
        logic [3:0] dn;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input logic r, input logic [3:0] rq, input logic [3:0] w,
                     input logic s, input logic [3:0] g, input logic [3:0] d, input logic b);
        vec_t e;
        e.rst = r; e.req = rq; e.width = w; e.sig = s; e.gnt = g; e.dn = d; e.bsy = b;
        vecs.push_back(e);
    endtask

    // Structural invariants on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv_sig_eq_or_grant", 32'(signal), 32'(|grant));
            chk("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("inv_done_in_grant", 32'(done & ~grant), 32'd0);
            chk("inv_idle_low", 32'(!busy && signal), 32'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi, done_at, low;
        bit seen;

        rst = 1'b0; req = '0; width = '0;
        rst0 = 1'b0; req0 = '0; width0 = '0;

        // reset, then requester 0 width 3 held
        v(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        v(1, 4'b0001, 3, 1, 4'b0001, 4'b0000, 1);
        v(1, 4'b0001, 3, 1, 4'b0001, 4'b0000, 1);
        v(1, 4'b0001, 3, 1, 4'b0001, 4'b0001, 1);
        v(1, 4'b0001, 3, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0001, 3, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0001, 3, 0, 4'b0000, 4'b0000, 0);
        v(1, 4'b0001, 3, 1, 4'b0001, 4'b0000, 1);
        // req dropped mid-pulse: pulse runs to completion
        v(1, 4'b0000, 0, 1, 4'b0001, 4'b0000, 1);
        v(1, 4'b0000, 0, 1, 4'b0001, 4'b0001, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // width 0 treated as 1
        v(1, 4'b0100, 0, 1, 4'b0100, 4'b0100, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // reset during 2nd cycle of width-5 pulse
        v(1, 4'b0010, 5, 1, 4'b0010, 4'b0000, 1);
        v(1, 4'b0010, 5, 1, 4'b0010, 4'b0000, 1);
        v(0, 4'b0010, 5, 0, 4'b0000, 4'b0000, 0);
        v(1, 4'b0011, 1, 1, 4'b0001, 4'b0001, 1);
        v(1, 4'b0011, 1, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0011, 1, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0011, 1, 0, 4'b0000, 4'b0000, 0);
        v(1, 4'b0011, 1, 1, 4'b0010, 4'b0010, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // width change and req[3] during requester 0's pulse
        v(1, 4'b0001, 3, 1, 4'b0001, 4'b0000, 1);
        v(1, 4'b1000, 7, 1, 4'b0001, 4'b0000, 1);
        v(1, 4'b1000, 7, 1, 4'b0001, 4'b0001, 1);
        v(1, 4'b1000, 7, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b1000, 7, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b1000, 7, 0, 4'b0000, 4'b0000, 0);
        v(1, 4'b1000, 7, 1, 4'b1000, 4'b0000, 1);
        for (int i = 0; i < 5; i++) v(1, 4'b0000, 0, 1, 4'b1000, 4'b0000, 1);
        v(1, 4'b0000, 0, 1, 4'b1000, 4'b1000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // after requester 2, pending {3,1}: 3 wins
        v(1, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1);
        v(1, 4'b1010, 1, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b1010, 1, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b1010, 1, 0, 4'b0000, 4'b0000, 0);
        v(1, 4'b1010, 1, 1, 4'b1000, 4'b1000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; req = vecs[i].req; width = vecs[i].width;
            tick();
            chk($sformatf("vec%0d_signal", i), 32'(signal), 32'(vecs[i].sig));
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            if (i == 0) inv_en = 1;
        end

        // maximum width 15 (pointer is 3 here, req[0] wins)
        @(negedge clk);
        req = 4'b0001; width = 4'd15;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (signal) seen = 1;
        end
        chk("maxw_started", 32'(seen), 32'd1);
        hi = 0; done_at = 0;
        for (int c = 0; c < 40 && signal; c++) begin
            hi++;
            if (done[0]) done_at = hi;
            @(negedge clk);
            req = 4'b0000;
            tick();
        end
        chk("maxw_len", 32'(hi), 32'd15);
        chk("maxw_done_pos", 32'(done_at), 32'd15);

        // rotation with all requesters held, width 1
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; width = 4'd1;
        for (int k = 0; k < 5; k++) begin
            low = 0; seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                if (signal) seen = 1;
                else low++;
            end
            chk($sformatf("rot%0d_seen", k), 32'(seen), 32'd1);
            chk($sformatf("rot%0d_grant", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rot%0d_done", k), 32'(done), 32'(4'b0001 << (k % 4)));
            if (k > 0) chk($sformatf("rot%0d_gap", k), 32'(low), 32'd3);
        end
        @(negedge clk);
        req = '0;

        // GAP=0 instance: 2 high, 1 low, busy low for exactly one cycle
        @(negedge clk);
        rst0 = 1'b1; req0 = 4'b0001; width0 = 4'd2;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("ng%0d_signal", k), 32'(signal0), 32'((k % 3) != 0));
            chk($sformatf("ng%0d_busy", k), 32'(busy0), 32'((k % 3) != 0));
            chk($sformatf("ng%0d_done", k), 32'(done0), 32'(((k % 3) == 2) ? 4'b0001 : 4'b0000));
            chk($sformatf("ng%0d_grant", k), 32'(grant0), 32'(((k % 3) != 0) ? 4'b0001 : 4'b0000));
        end

        inv_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
